// File: rtl/fb_rect_fill.sv
// ---------------------------------------------------------------------------
// fb_rect_fill : rectangle-fill write engine for the RGB332 framebuffer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fb_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x0,
  input  logic [9:0]        cmd_y0,
  input  logic [9:0]        cmd_x1,
  input  logic [9:0]        cmd_y1,
  input  logic [7:0]        cmd_color,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        dout,
  output logic              wen,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [9:0]        X_MAX  = 10'(H_RES - 1);
  localparam logic [9:0]        Y_MAX  = 10'(V_RES - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(H_RES);

  state_t              state_q, state_d;
  logic [9:0]          x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [9:0]          x_q, x_d, y_q, y_d;
  logic [7:0]          color_q, color_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          dout_q, dout_d;
  logic                wen_q, wen_d, done_q, done_d, busy_q, busy_d;
  logic                ready_q, ready_d;
  logic [9:0]          x1c, y1c;
  logic                empty;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    wen_d      = 1'b0;
    done_d     = 1'b0;
    x1c        = (x1_q > X_MAX) ? X_MAX : x1_q;
    y1c        = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    empty      = (x0_q > x1c) || (y0_q > y1c) || (x0_q > X_MAX) || (y0_q > Y_MAX);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          x1_d    = cmd_x1;
          y1_d    = cmd_y1;
          color_d = cmd_color;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        // x1/y1 are overwritten with their clamped values so FILL compares directly
        x1_d       = x1c;
        y1_d       = y1c;
        x_d        = x0_q;
        y_d        = y0_q;
        row_base_d = ADDR_W'(y0_q) * STRIDE;
        state_d    = empty ? S_DONE : S_FILL;
      end
      S_FILL: begin
        wen_d  = 1'b1;
        addr_d = row_base_q + ADDR_W'(x_q);
        dout_d = color_q;
        if (x_q == x1_q) begin
          if (y_q == y1_q) begin
            state_d = S_DONE;
          end else begin
            x_d        = x0_q;
            y_d        = y_q + 10'd1;
            row_base_d = row_base_q + STRIDE;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign addr      = addr_q;
  assign dout      = dout_q;
  assign wen       = wen_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire
